// File: rtl/mips_pkg.sv
// Shared types for the memory-stage datapath: store sizes and store sequencer states.
package mips_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } store_size_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } sm_state_t;

endpackage

// File: rtl/lane_merge.sv
// Places the low byte/half/word of new data into its little-endian lane of an old word.
module lane_merge
  import mips_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_data_i,
  input  store_size_t size_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_word_i;
    case (size_i)
      SZ_BYTE: merged_o[{addr_lo_i, 3'b000} +: 8]     = new_data_i[7:0];
      SZ_HALF: merged_o[{addr_lo_i[1], 4'b0000} +: 16] = new_data_i[15:0];
      SZ_WORD: merged_o = new_data_i;
      default: merged_o = old_word_i;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store sequencer for a word-only data memory: word stores write directly,
// sub-word stores do read-modify-write, bad size/alignment responds with err.
module store_merge_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        done,
  output logic        err
);

  sm_state_t   state_q;
  store_size_t size_q;
  store_size_t req_size_e;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] merged_d;
  logic        ready_q;
  logic        re_q;
  logic        we_q;
  logic        done_q;
  logic        err_q;

  assign req_size_e = store_size_t'(req_size);

  lane_merge u_lane_merge (
    .old_word_i (mem_rdata),
    .new_data_i (wdata_q),
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .merged_o   (merged_d)
  );

  // Strobes, done and err are registered alongside the state so no output
  // depends combinationally on mem_ack or req_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      size_q      <= SZ_BYTE;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_wdata_q <= '0;
      ready_q     <= 1'b1;
      re_q        <= 1'b0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            size_q  <= req_size_e;
            ready_q <= 1'b0;
            if (req_size_e == SZ_WORD && req_addr[1:0] == 2'b00) begin
              mem_wdata_q <= req_wdata;
              we_q        <= 1'b1;
              state_q     <= WRITE;
            end else if (req_size_e == SZ_BYTE ||
                         (req_size_e == SZ_HALF && !req_addr[0])) begin
              re_q    <= 1'b1;
              state_q <= READ;
            end else begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= RESP;
            end
          end
        end
        READ: begin
          if (mem_ack) begin
            mem_wdata_q <= merged_d;
            re_q        <= 1'b0;
            we_q        <= 1'b1;
            state_q     <= WRITE;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          re_q    <= 1'b0;
          we_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign mem_wdata = mem_wdata_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit with a wait-state-programmable memory responder.
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        done;
  logic        err;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Memory model controls, written only by the stimulus thread
  logic [31:0] memWord = '0;
  logic [31:0] expAddr = '0;
  int readWait = 0;
  int writeWait = 0;

  // Monitor-owned counters and records
  int waitCnt = 0;
  int nReads = 0, nWrites = 0, nDone = 0, nErr = 0;
  int reCycles = 0, weCycles = 0, bothHigh = 0, addrBad = 0, readyBusy = 0;
  int wrAckCyc = 0;
  logic [31:0] lastRdAddr = '0, lastWrAddr = '0, lastWrData = '0;

  // Stimulus results
  int issueCyc, relDone;
  int dReads, dWrites, dDone, dErr, dRe, dWe, dBoth, dAddrBad, dReadyBusy;
  logic gotDone, readyAfter;

  store_merge_unit dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Memory responder and observer: decides ack for the upcoming edge
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_re && mem_we) bothHigh++;
    if ((mem_re || mem_we) && mem_addr !== expAddr) addrBad++;
    if (req_ready && (mem_re || mem_we || done)) readyBusy++;
    if (!(mem_re || mem_we)) waitCnt = 0;
    if (mem_re) begin
      reCycles++;
      if (waitCnt < readWait) waitCnt++;
      else begin
        mem_ack = 1'b1;
        mem_rdata = memWord;
        lastRdAddr = mem_addr;
        nReads++;
        waitCnt = 0;
      end
    end else if (mem_we) begin
      weCycles++;
      if (waitCnt < writeWait) waitCnt++;
      else begin
        mem_ack = 1'b1;
        lastWrAddr = mem_addr;
        lastWrData = mem_wdata;
        wrAckCyc = cyc;
        nWrites++;
        waitCnt = 0;
      end
    end
    if (done) begin
      nDone++;
      if (err) nErr++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [1:0] size, input logic [31:0] rdata,
                               input int rw, input int ww, input bit hold);
    int s0, s1, s2, s3, s4, s5, s6, s7, s8;
    @(negedge clk);
    memWord = rdata; readWait = rw; writeWait = ww;
    expAddr = {addr[31:2], 2'b00};
    s0 = nReads; s1 = nWrites; s2 = nDone; s3 = nErr; s4 = reCycles;
    s5 = weCycles; s6 = bothHigh; s7 = addrBad; s8 = readyBusy;
    req_valid = 1'b1; req_addr = addr; req_wdata = data; req_size = size;
    issueCyc = cyc;
    @(negedge clk);
    if (hold) begin
      req_addr = 32'h0000_0300; req_size = 2'b10; req_wdata = 32'hBAD0_BAD0;
    end else req_valid = 1'b0;
    gotDone = 1'b0;
    relDone = -1;
    for (int i = 0; i < 40 && !gotDone; i++) begin
      if (done) begin
        gotDone = 1'b1;
        relDone = cyc - issueCyc;
        req_valid = 1'b0;
      end else @(negedge clk);
    end
    req_valid = 1'b0;
    @(negedge clk);
    readyAfter = req_ready;
    dReads = nReads - s0; dWrites = nWrites - s1; dDone = nDone - s2; dErr = nErr - s3;
    dRe = reCycles - s4; dWe = weCycles - s5; dBoth = bothHigh - s6;
    dAddrBad = addrBad - s7; dReadyBusy = readyBusy - s8;
    checkOutput("done_seen", {31'd0, gotDone}, 32'd1);
    checkOutput("done_count", dDone, 32'd1);
    checkOutput("ready_after", {31'd0, readyAfter}, 32'd1);
    checkOutput("both_strobes", dBoth, 32'd0);
    checkOutput("ready_busy", dReadyBusy, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("rst_re", {31'd0, mem_re}, 32'd0);
    checkOutput("rst_we", {31'd0, mem_we}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_addr", mem_addr, 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    // Word store, zero-wait
    applyStimulus(32'h100, 32'hDEADBEEF, 2'b10, 32'h0, 0, 0, 1'b0);
    checkOutput("word_reads", dRe, 32'd0);
    checkOutput("word_writes", dWrites, 32'd1);
    checkOutput("word_waddr", lastWrAddr, 32'h100);
    checkOutput("word_wdata", lastWrData, 32'hDEADBEEF);
    checkOutput("word_latency", relDone, 32'd2);
    checkOutput("word_err", dErr, 32'd0);

    // Byte store, lane 3
    applyStimulus(32'h103, 32'h123456AB, 2'b00, 32'h11223344, 0, 0, 1'b0);
    checkOutput("b3_raddr", lastRdAddr, 32'h100);
    checkOutput("b3_reads", dReads, 32'd1);
    checkOutput("b3_wdata", lastWrData, 32'hAB223344);
    checkOutput("b3_latency", relDone, 32'd3);
    checkOutput("b3_err", dErr, 32'd0);

    // Byte store, lane 1
    applyStimulus(32'h101, 32'hFFFFFFCD, 2'b00, 32'h11223344, 0, 0, 1'b0);
    checkOutput("b1_wdata", lastWrData, 32'h1122CD44);

    // Half stores, upper then lower
    applyStimulus(32'h102, 32'hFFFF1234, 2'b01, 32'h11223344, 0, 0, 1'b0);
    checkOutput("h1_wdata", lastWrData, 32'h12343344);
    checkOutput("h1_waddr", lastWrAddr, 32'h100);
    applyStimulus(32'h100, 32'hFFFF1234, 2'b01, 32'h11223344, 0, 0, 1'b0);
    checkOutput("h0_wdata", lastWrData, 32'h11221234);

    // Error requests: misaligned half, misaligned word, reserved size
    applyStimulus(32'h101, 32'h1, 2'b01, 32'h0, 0, 0, 1'b0);
    checkOutput("eh_err", dErr, 32'd1);
    checkOutput("eh_latency", relDone, 32'd1);
    checkOutput("eh_strobes", dRe + dWe, 32'd0);
    applyStimulus(32'h102, 32'h1, 2'b10, 32'h0, 0, 0, 1'b0);
    checkOutput("ew_err", dErr, 32'd1);
    checkOutput("ew_latency", relDone, 32'd1);
    checkOutput("ew_strobes", dRe + dWe, 32'd0);
    applyStimulus(32'h100, 32'h1, 2'b11, 32'h0, 0, 0, 1'b0);
    checkOutput("er_err", dErr, 32'd1);
    checkOutput("er_latency", relDone, 32'd1);
    checkOutput("er_strobes", dRe + dWe, 32'd0);

    // Wait states with a competing request held on the inputs
    applyStimulus(32'h202, 32'h00000077, 2'b00, 32'hAABBCCDD, 3, 2, 1'b1);
    checkOutput("ws_re_cycles", dRe, 32'd4);
    checkOutput("ws_we_cycles", dWe, 32'd3);
    checkOutput("ws_addr_stable", dAddrBad, 32'd0);
    checkOutput("ws_writes", dWrites, 32'd1);
    checkOutput("ws_wdata", lastWrData, 32'hAA77CCDD);
    checkOutput("ws_done_after_ack", issueCyc + relDone - wrAckCyc, 32'd1);
    checkOutput("ws_latency", relDone, 32'd8);

    // Reset during a READ wait
    begin
      int sd, sw;
      @(negedge clk);
      memWord = 32'h0; readWait = 20; writeWait = 0; expAddr = 32'h100;
      sd = nDone; sw = nWrites;
      req_valid = 1'b1; req_addr = 32'h100; req_wdata = 32'h55; req_size = 2'b00;
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("abort_in_read", {31'd0, mem_re}, 32'd1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abort_ready", {31'd0, req_ready}, 32'd1);
      checkOutput("abort_re", {31'd0, mem_re}, 32'd0);
      checkOutput("abort_we", {31'd0, mem_we}, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("abort_no_done", nDone - sd, 32'd0);
      checkOutput("abort_no_write", nWrites - sw, 32'd0);
    end

    applyStimulus(32'h100, 32'h00000055, 2'b00, 32'h00000000, 0, 0, 1'b0);
    checkOutput("post_wdata", lastWrData, 32'h00000055);
    checkOutput("post_latency", relDone, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_merge_unit.md
# store_merge_unit

Store-side datapath and sequencer for the data-memory port: the narrowing counterpart to the load-path sign/zero extension. It takes a 32-bit register value plus a store size (byte/half/word), truncates and places it in the correct byte lane, and writes it to a word-only data memory. Sub-word stores use a read-modify-write sequence. Sits between the execute/memory pipeline stage and the data memory; stalls the pipeline through `req_ready`/`done`.

## Interface
Parameters:
- none; address and data fixed at 32 bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_addr  in  32  byte address
- req_wdata  in  32  register value; only low 8/16/32 bits used per size
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- mem_addr  out  32  word address, `{req_addr[31:2],2'b00}`, held for whole transaction
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_wdata  out  32  full merged word to write
- mem_rdata  in  32  read data, valid when `mem_ack` is high during READ
- mem_ack  in  1  memory completes current read or write this cycle
- done  out  1  one-cycle pulse: request finished (success or error)
- err  out  1  one-cycle pulse coincident with `done`: misaligned or reserved size

## Operation
- Handshake: request accepted on a cycle where `req_valid && req_ready`; addr/wdata/size registered then; inputs ignored until return to IDLE.
- States: IDLE, READ, WRITE, RESP.
- IDLE → WRITE if size=word and addr[1:0]=00.
- IDLE → READ if size=byte, or size=half and addr[0]=0.
- IDLE → RESP with err set if size=11, half with addr[0]=1, or word with addr[1:0]≠00. No memory strobe is ever asserted for an error request.
- READ: `mem_re`=1. On `mem_ack`, merge the registered data into `mem_rdata` and register the result. Then → WRITE.
- WRITE: `mem_we`=1, `mem_wdata` = merged word, or `req_wdata` for a word store. On `mem_ack` → RESP.
- RESP: `done`=1, `err` as flagged; → IDLE unconditionally.
- Lane rules (little-endian):
  - byte k = addr[1:0] replaces bits [8k+7:8k] with wdata[7:0];
  - half h = addr[1] replaces bits [16h+15:16h] with wdata[15:0];
  - all other bits come from `mem_rdata`.
  - Upper bits of wdata beyond the size are discarded, with no sign or overflow check.
- `mem_re` and `mem_we` are never high together; `mem_ack` outside READ/WRITE is ignored.

## Timing
- Reset values: `req_ready`=1 (state IDLE), `mem_re`=`mem_we`=`done`=`err`=0, `mem_addr`=0, `mem_wdata`=0.
- All outputs are registered or decoded purely from state/registers; no combinational path from `mem_ack` or `req_valid` to any output.
- Zero-wait memory (ack in first strobe cycle), with request accepted at edge 0:
  - word: WRITE cycle 1, `done` cycle 2, `req_ready` cycle 3;
  - sub-word: READ cycle 1, WRITE cycle 2, `done` cycle 3;
  - error: `done`/`err` cycle 1.
- Each memory wait cycle extends READ or WRITE by one cycle; strobe and address stay stable until ack.
- Throughput: at most one request per (latency+1) cycles; `req_ready` is low in READ/WRITE/RESP.
- Reset mid-transaction: at the reset edge, state returns to IDLE and strobes drop the same edge. The aborted request produces no `done`, and any partial write is not retried.

## Structure
- Shared package `mips_pkg`:
  - `store_size_t` enum (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD);
  - `sm_state_t` enum (IDLE, READ, WRITE, RESP).
- One combinational sub-module `lane_merge`:
  - inputs: old word, new data, size, addr[1:0];
  - output: merged word;
  - reusable by a future byte-enable memory wrapper.
- FSM, request registers and merged-word register live in `store_merge_unit`.

## Test plan
- Word store, addr 0x100, data 0xDEADBEEF, immediate ack → no `mem_re`; single write of 0xDEADBEEF to 0x100; `done` 2 cycles after accept, `err`=0.
- Byte store, addr 0x103, data 0x123456AB, `mem_rdata`=0x11223344 → read at 0x100, then write 0xAB223344.
- Half store, addr 0x102, data 0xFFFF1234, rdata 0x11223344 → write 0x12343344. Same at addr 0x100 → write 0x11221234.
- Misaligned half at 0x101, word at 0x102, and size=11 → `done`+`err` one cycle after accept; `mem_re`/`mem_we` never asserted.
- `mem_ack` held low 3 cycles in READ and 2 cycles in WRITE → strobes and `mem_addr` stable throughout; `done` exactly one cycle after the write ack; new `req_valid` held during this time is not accepted.
- Reset asserted during READ wait → next cycle IDLE with all strobes low and no `done`. A following byte store completes normally.
